// File: rtl/watch_pkg.sv
// watch_pkg
// Shared encodings for the watch time-adjust arbiter:
//   - request source encoding (SRC_BTN / SRC_UART)
//   - adjust field enum (FLD_SEC / FLD_MIN / FLD_HOUR)
//   - arbiter FSM state enum (ST_IDLE / ST_ISSUE / ST_GAP)
//   - pick_field(): fixed hour > min > sec field priority
package watch_pkg;

    localparam logic SRC_BTN  = 1'b0;
    localparam logic SRC_UART = 1'b1;

    typedef enum logic [1:0] {
        FLD_SEC  = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_HOUR = 2'd2
    } fld_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // pend = {hour, min, sec} pending flags of one source.
    function automatic fld_e pick_field(input logic [2:0] pend);
        if (pend[2]) begin
            return FLD_HOUR;
        end else if (pend[1]) begin
            return FLD_MIN;
        end else if (pend[0]) begin
            return FLD_SEC;
        end else begin
            return FLD_SEC;
        end
    endfunction

endpackage

// File: rtl/watch_adj_pend_cnt.sv
// watch_adj_pend_cnt
// Saturating pending-request counter for one source/field pair.
// Ports:
//   clk     system clock
//   rst     asynchronous active-low reset
//   i_inc   new request this cycle
//   i_dec   request issued this cycle (only asserted while count is non-zero)
//   o_cnt   current pending count
//   o_drop  request lost this cycle because the counter is already full
module watch_adj_pend_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_drop
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_full;
    logic             w_empty;

    assign w_full  = &r_cnt;
    assign w_empty = (r_cnt == '0);

    // A simultaneous issue frees a slot, so the request is kept in that case.
    assign o_drop = i_inc & ~i_dec & w_full;
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && !w_full) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_dec && !i_inc && !w_empty) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/watch_adj_arbiter.sv
// watch_adj_arbiter
// Shares the watch sec/min/hour "plus" adjust pulses between the debounced
// buttons (BTN) and the UART command decoder (UART). Requests are queued per
// source and field, one pulse is issued at a time followed by GAP_CYC idle
// cycles, and the two sources alternate round-robin.
// Build option: define WATCH_ARB_UART_PRIO_EN to give UART fixed priority over
// BTN instead of round-robin.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   i_btn_*_plus             BTN request pulses
//   i_uart_*_plus            UART request pulses
//   i_lock                   hold off new issues, keep queuing
//   i_ovf_clr                clear sticky overflow flag
//   o_sec/min/hour_plus      one-cycle adjust pulses to watch_top
//   o_busy                   arbiter active or requests pending
//   o_last_src               source of the last issued pulse (0=BTN, 1=UART)
//   o_ovf                    sticky: a request was dropped at saturation
module watch_adj_arbiter
    import watch_pkg::*;
#(
    parameter int CNT_W   = 3,
    parameter int GAP_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_sec_plus,
    input  logic i_btn_min_plus,
    input  logic i_btn_hour_plus,
    input  logic i_uart_sec_plus,
    input  logic i_uart_min_plus,
    input  logic i_uart_hour_plus,
    input  logic i_lock,
    input  logic i_ovf_clr,
    output logic o_sec_plus,
    output logic o_min_plus,
    output logic o_hour_plus,
    output logic o_busy,
    output logic o_last_src,
    output logic o_ovf
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    // Indexed [source][field], field order {hour, min, sec}.
    logic [1:0][2:0]  w_req;
    logic [1:0][2:0]  w_dec;
    logic [1:0][2:0]  w_drop;
    logic [1:0][2:0]  w_pend;
    logic [CNT_W-1:0] w_cnt [2][3];

    logic             w_btn_any;
    logic             w_uart_any;
    logic             w_sel_src;
    fld_e             w_sel_fld;
    logic             w_start;

    state_e           r_state;
    logic [GAP_W-1:0] r_gap;
    logic             r_sec_plus;
    logic             r_min_plus;
    logic             r_hour_plus;
    logic             r_busy;
    logic             r_last_src;
    logic             r_ovf;
`ifndef WATCH_ARB_UART_PRIO_EN
    logic             r_rr;
`endif

    assign w_req[SRC_BTN]  = {i_btn_hour_plus, i_btn_min_plus, i_btn_sec_plus};
    assign w_req[SRC_UART] = {i_uart_hour_plus, i_uart_min_plus, i_uart_sec_plus};

    for (genvar s = 0; s < 2; s++) begin : g_src
        for (genvar f = 0; f < 3; f++) begin : g_fld
            watch_adj_pend_cnt #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk    (clk),
                .rst    (rst),
                .i_inc  (w_req[s][f]),
                .i_dec  (w_dec[s][f]),
                .o_cnt  (w_cnt[s][f]),
                .o_drop (w_drop[s][f])
            );
            assign w_pend[s][f] = |w_cnt[s][f];
        end
    end

    // Source/field selection for the next issue.
    always_comb begin
        w_btn_any  = |w_pend[SRC_BTN];
        w_uart_any = |w_pend[SRC_UART];
`ifdef WATCH_ARB_UART_PRIO_EN
        w_sel_src  = w_uart_any ? SRC_UART : SRC_BTN;
`else
        if (r_rr == SRC_UART) begin
            w_sel_src = w_uart_any ? SRC_UART : SRC_BTN;
        end else begin
            w_sel_src = w_btn_any ? SRC_BTN : SRC_UART;
        end
`endif
        w_sel_fld = pick_field(w_pend[w_sel_src]);
        w_start   = (r_state == ST_IDLE) && !i_lock && (w_btn_any || w_uart_any);
    end

    // The selected counter is decremented in the same cycle the issue is latched.
    always_comb begin
        w_dec = '0;
        for (int s = 0; s < 2; s++) begin
            for (int f = 0; f < 3; f++) begin
                w_dec[s][f] = w_start && (w_sel_src == s[0]) &&
                              (w_sel_fld == fld_e'(f[1:0]));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_gap       <= '0;
            r_sec_plus  <= 1'b0;
            r_min_plus  <= 1'b0;
            r_hour_plus <= 1'b0;
            r_busy      <= 1'b0;
            r_last_src  <= SRC_BTN;
            r_ovf       <= 1'b0;
`ifndef WATCH_ARB_UART_PRIO_EN
            r_rr        <= SRC_BTN;
`endif
        end else begin
            r_sec_plus  <= 1'b0;
            r_min_plus  <= 1'b0;
            r_hour_plus <= 1'b0;
            r_busy      <= (r_state != ST_IDLE) || (|w_pend);

            // Set has priority over clear.
            if (|w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_ISSUE;
                        r_last_src <= w_sel_src;
`ifndef WATCH_ARB_UART_PRIO_EN
                        r_rr       <= ~w_sel_src;
`endif
                        case (w_sel_fld)
                            FLD_HOUR: r_hour_plus <= 1'b1;
                            FLD_MIN:  r_min_plus  <= 1'b1;
                            default:  r_sec_plus  <= 1'b1;
                        endcase
                    end
                end
                ST_ISSUE: begin
                    if (GAP_CYC > 0) begin
                        r_state <= ST_GAP;
                        r_gap   <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_W'(GAP_CYC - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_sec_plus  = r_sec_plus;
    assign o_min_plus  = r_min_plus;
    assign o_hour_plus = r_hour_plus;
    assign o_busy      = r_busy;
    assign o_last_src  = r_last_src;
    assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_watch_adj_arbiter.sv
// tb_watch_adj_arbiter
// Scoreboard bench for watch_adj_arbiter (default parameters). Expected pulses
// (cycle, field, source) are queued when requests are driven and popped when
// the DUT pulses. Cycle 0 is the cycle in which the first request is driven.
// Honours WATCH_ARB_UART_PRIO_EN for the expected issue order.
module tb_watch_adj_arbiter;

    logic clk;
    logic rst;
    logic i_btn_sec_plus, i_btn_min_plus, i_btn_hour_plus;
    logic i_uart_sec_plus, i_uart_min_plus, i_uart_hour_plus;
    logic i_lock, i_ovf_clr;
    logic o_sec_plus, o_min_plus, o_hour_plus;
    logic o_busy, o_last_src, o_ovf;

    typedef struct {
        int         cyc;
        logic [2:0] fld;
        logic       src;
    } exp_t;

    localparam logic [2:0] P_SEC  = 3'b001;
    localparam logic [2:0] P_MIN  = 3'b010;
    localparam logic [2:0] P_HOUR = 3'b100;
    localparam logic       S_BTN  = 1'b0;
    localparam logic       S_UART = 1'b1;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    watch_adj_arbiter u_dut (
        .clk              (clk),
        .rst              (rst),
        .i_btn_sec_plus   (i_btn_sec_plus),
        .i_btn_min_plus   (i_btn_min_plus),
        .i_btn_hour_plus  (i_btn_hour_plus),
        .i_uart_sec_plus  (i_uart_sec_plus),
        .i_uart_min_plus  (i_uart_min_plus),
        .i_uart_hour_plus (i_uart_hour_plus),
        .i_lock           (i_lock),
        .i_ovf_clr        (i_ovf_clr),
        .o_sec_plus       (o_sec_plus),
        .o_min_plus       (o_min_plus),
        .o_hour_plus      (o_hour_plus),
        .o_busy           (o_busy),
        .o_last_src       (o_last_src),
        .o_ovf            (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs;
        i_btn_sec_plus   = 1'b0;
        i_btn_min_plus   = 1'b0;
        i_btn_hour_plus  = 1'b0;
        i_uart_sec_plus  = 1'b0;
        i_uart_min_plus  = 1'b0;
        i_uart_hour_plus = 1'b0;
        i_lock           = 1'b0;
        i_ovf_clr        = 1'b0;
    endtask

    // Leaves the bench 1 time unit after the first active edge out of reset.
    task automatic do_reset;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int c, input logic [2:0] f, input logic s);
        exp_t e;
        e.cyc = c;
        e.fld = f;
        e.src = s;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        logic [5:0] outs;
        #3;
        outs = {o_sec_plus, o_min_plus, o_hour_plus, o_busy, o_last_src, o_ovf};
        checks++;
        if (outs !== 6'b0) begin
            failures++;
            $display("FAIL reset_state: outputs=%b want 000000", outs);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            outs = {o_sec_plus, o_min_plus, o_hour_plus, o_busy, o_last_src, o_ovf};
            checks++;
            if (outs !== 6'b0) begin
                failures++;
                $display("FAIL reset_idle: cycle %0d outputs=%b want 000000", k, outs);
            end
        end
    endtask

    task automatic test_single;
        logic [2:0] pulse;
        logic       exp_busy;
        exp_t       e;
        do_reset();
        push_exp(2, P_SEC, S_BTN);
        for (int k = 0; k < 12; k++) begin
            i_btn_sec_plus = (k == 0);
            @(negedge clk);
            pulse = {o_hour_plus, o_min_plus, o_sec_plus};
            if (pulse != 3'b000) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL single: unexpected pulse %b at cycle %0d", pulse, k);
                end else begin
                    e = sb.pop_front();
                    if (pulse !== e.fld || o_last_src !== e.src || k !== e.cyc) begin
                        failures++;
                        $display("FAIL single: pulse=%b src=%b cyc=%0d want %b src=%b cyc=%0d",
                                 pulse, o_last_src, k, e.fld, e.src, e.cyc);
                    end
                end
            end
            exp_busy = (k >= 2) && (k <= 7);
            checks++;
            if (o_busy !== exp_busy) begin
                failures++;
                $display("FAIL single_busy: cycle %0d busy=%b want %b", k, o_busy, exp_busy);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL single: %0d expected pulses missing, got 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_simultaneous;
        logic [2:0] pulse;
        exp_t       e;
        do_reset();
`ifdef WATCH_ARB_UART_PRIO_EN
        push_exp(2, P_HOUR, S_UART);
        push_exp(8, P_MIN, S_BTN);
`else
        push_exp(2, P_MIN, S_BTN);
        push_exp(8, P_HOUR, S_UART);
`endif
        for (int k = 0; k < 14; k++) begin
            i_btn_min_plus   = (k == 0);
            i_uart_hour_plus = (k == 0);
            @(negedge clk);
            pulse = {o_hour_plus, o_min_plus, o_sec_plus};
            if (pulse != 3'b000) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL simul: unexpected pulse %b at cycle %0d", pulse, k);
                end else begin
                    e = sb.pop_front();
                    if (pulse !== e.fld || o_last_src !== e.src || k !== e.cyc) begin
                        failures++;
                        $display("FAIL simul: pulse=%b src=%b cyc=%0d want %b src=%b cyc=%0d",
                                 pulse, o_last_src, k, e.fld, e.src, e.cyc);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL simul: %0d expected pulses missing, got 0", sb.size());
            sb.delete();
        end
    endtask

    // BTN sec+min+hour and UART min in cycle 0; then BTN sec and UART sec in
    // cycle 30 with both queues refilled, to exercise rr/priority twice.
    task automatic test_arbitration;
        logic [2:0] pulse;
        exp_t       e;
        do_reset();
`ifdef WATCH_ARB_UART_PRIO_EN
        push_exp(2, P_MIN, S_UART);
        push_exp(8, P_HOUR, S_BTN);
        push_exp(14, P_MIN, S_BTN);
        push_exp(20, P_SEC, S_BTN);
        push_exp(32, P_SEC, S_UART);
        push_exp(38, P_SEC, S_UART);
        push_exp(44, P_SEC, S_BTN);
        push_exp(50, P_SEC, S_BTN);
`else
        push_exp(2, P_HOUR, S_BTN);
        push_exp(8, P_MIN, S_UART);
        push_exp(14, P_MIN, S_BTN);
        push_exp(20, P_SEC, S_BTN);
        // rr pointer now points at UART (last issue was BTN).
        push_exp(32, P_SEC, S_UART);
        push_exp(38, P_SEC, S_BTN);
        push_exp(44, P_SEC, S_UART);
        push_exp(50, P_SEC, S_BTN);
`endif
        for (int k = 0; k < 58; k++) begin
            i_btn_sec_plus  = (k == 0) || (k == 30) || (k == 31);
            i_btn_min_plus  = (k == 0);
            i_btn_hour_plus = (k == 0);
            i_uart_min_plus = (k == 0);
            i_uart_sec_plus = (k == 30) || (k == 31);
            @(negedge clk);
            pulse = {o_hour_plus, o_min_plus, o_sec_plus};
            if (pulse != 3'b000) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL arb: unexpected pulse %b at cycle %0d", pulse, k);
                end else begin
                    e = sb.pop_front();
                    if (pulse !== e.fld || o_last_src !== e.src || k !== e.cyc) begin
                        failures++;
                        $display("FAIL arb: pulse=%b src=%b cyc=%0d want %b src=%b cyc=%0d",
                                 pulse, o_last_src, k, e.fld, e.src, e.cyc);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL arb: %0d expected pulses missing, got 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_lock_sat;
        logic [2:0] pulse;
        logic       exp_ovf;
        exp_t       e;
        do_reset();
        // Nine requests, only seven fit; lock released in cycle 12.
        for (int j = 0; j < 7; j++) begin
            push_exp(13 + 6 * j, P_SEC, S_UART);
        end
        for (int k = 0; k < 70; k++) begin
            i_lock          = (k < 12);
            i_uart_sec_plus = (k <= 8);
            i_ovf_clr       = (k == 60);
            @(negedge clk);
            pulse = {o_hour_plus, o_min_plus, o_sec_plus};
            if (pulse != 3'b000) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL lock_sat: unexpected pulse %b at cycle %0d", pulse, k);
                end else begin
                    e = sb.pop_front();
                    if (pulse !== e.fld || o_last_src !== e.src || k !== e.cyc) begin
                        failures++;
                        $display("FAIL lock_sat: pulse=%b src=%b cyc=%0d want %b src=%b cyc=%0d",
                                 pulse, o_last_src, k, e.fld, e.src, e.cyc);
                    end
                end
            end
            exp_ovf = (k >= 8) && (k <= 60);
            checks++;
            if (o_ovf !== exp_ovf) begin
                failures++;
                $display("FAIL lock_ovf: cycle %0d ovf=%b want %b", k, o_ovf, exp_ovf);
            end
            if (k == 10) begin
                checks++;
                if (o_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL lock_busy: cycle %0d busy=%b want 1", k, o_busy);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL lock_sat: %0d expected pulses missing, got 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid;
        logic [2:0] pulse;
        logic [5:0] outs;
        exp_t       e;
        do_reset();
        // Four BTN sec requests queued under lock; first issue lands in cycle 5.
        push_exp(5, P_SEC, S_BTN);
        for (int k = 0; k <= 5; k++) begin
            i_lock         = (k < 4);
            i_btn_sec_plus = (k < 4);
            @(negedge clk);
            pulse = {o_hour_plus, o_min_plus, o_sec_plus};
            if (pulse != 3'b000) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL rst_mid: unexpected pulse %b at cycle %0d", pulse, k);
                end else begin
                    e = sb.pop_front();
                    if (pulse !== e.fld || o_last_src !== e.src || k !== e.cyc) begin
                        failures++;
                        $display("FAIL rst_mid: pulse=%b src=%b cyc=%0d want %b src=%b cyc=%0d",
                                 pulse, o_last_src, k, e.fld, e.src, e.cyc);
                    end
                end
            end
            if (k < 5) begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rst_mid: %0d expected pulses missing, got 0", sb.size());
            sb.delete();
        end
        // Still inside the ISSUE cycle: reset must cut the pulse at once.
        #1;
        rst = 1'b0;
        #1;
        outs = {o_sec_plus, o_min_plus, o_hour_plus, o_busy, o_last_src, o_ovf};
        checks++;
        if (outs !== 6'b0) begin
            failures++;
            $display("FAIL rst_mid_async: outputs=%b want 000000", outs);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            outs = {o_sec_plus, o_min_plus, o_hour_plus, o_busy, o_last_src, o_ovf};
            checks++;
            if (outs !== 6'b0) begin
                failures++;
                $display("FAIL rst_mid_after: cycle %0d outputs=%b want 000000", k, outs);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_simultaneous();
        test_arbitration();
        test_lock_sat();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/watch_adj_arbiter.md
Name: watch_adj_arbiter

Overview:
- Shares the watch time-adjust interface (sec/min/hour "plus" pulses into watch_top) between two requesters: debounced buttons (BTN) and the UART command decoder (UART).
- Queues requests per source and field in saturating counters.
- Issues one adjust pulse at a time, with a guaranteed idle gap between pulses, using round-robin between the two sources.

Parameters:
- CNT_W, 3: pending-counter width per source/field; at most 2^CNT_W-1 requests held.
- GAP_CYC, 4: idle cycles inserted after each issued pulse (0 allowed; 0 skips the GAP state).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- i_btn_sec_plus / i_btn_min_plus / i_btn_hour_plus  in  1 each  BTN request pulses (1 cycle)
- i_uart_sec_plus / i_uart_min_plus / i_uart_hour_plus  in  1 each  UART request pulses (1 cycle)
- i_lock  in  1  high: no new issue starts; pending requests retained
- i_ovf_clr  in  1  clears o_ovf
- o_sec_plus / o_min_plus / o_hour_plus  out  1 each  one-cycle adjust pulses to watch_top
- o_busy  out  1  state != IDLE, or any pending counter non-zero
- o_last_src  out  1  source of the most recent issued pulse (0=BTN, 1=UART)
- o_ovf  out  1  sticky: a request was dropped at saturation

Behaviour:
- Reset (rst=0, async): all six counters=0, state=IDLE, rr pointer=BTN, all outputs 0. Output pulses drop immediately.
- Counters: six CNT_W-bit counters, one per source x field.
  - Request only: +1. Issue only: -1. Request and issue in the same cycle: unchanged.
  - Request while at max with no same-cycle issue: dropped, counter stays at max, o_ovf set next edge.
- o_ovf: set wins over i_ovf_clr in the same cycle; otherwise i_ovf_clr clears it.
- FSM states IDLE, ISSUE, GAP; Moore outputs.
  - IDLE, leaving when i_lock=0 and any counter is non-zero:
    - Select the source: rr pointer source if it has pending work, else the other source.
    - Select the field within that source: hour > min > sec.
    - Latch source and field, decrement the selected counter, set o_last_src, set rr pointer to the other source, go to ISSUE.
  - ISSUE: exactly the latched o_*_plus is high for this one cycle. Next state is GAP if GAP_CYC>0, else IDLE.
  - GAP: count GAP_CYC cycles, then IDLE. i_lock has no effect on ISSUE or GAP in progress.
- Latency: a request in cycle 0 with the arbiter idle gives the pulse in cycle 2.
- Pulse spacing:
  - Back-to-back pulses are GAP_CYC+2 cycles apart (6 at default).
  - With GAP_CYC=0 they are 2 cycles apart.
- Never more than one o_*_plus high in any cycle.
- i_lock=1 held: counters keep accumulating and saturating; no pulses are issued.

Optional Feature:
- Macro WATCH_ARB_UART_PRIO_EN.
- Defined: fixed priority, UART always wins over BTN when both are pending; rr pointer is unused and o_last_src still updates.
- Undefined: round-robin as described above.

Decomposition:
- Package watch_pkg holds:
  - source encoding SRC_BTN=0, SRC_UART=1
  - field enum FLD_SEC, FLD_MIN, FLD_HOUR
  - FSM state enum ST_IDLE, ST_ISSUE, ST_GAP
- Sub-module watch_adj_pend_cnt: saturating up/down counter with inc, dec, sat-drop flag and count outputs; instanced six times.
- Selection logic and the FSM stay in watch_adj_arbiter.

Test Plan:
- Reset: assert rst=0 mid-run -> all o_* = 0 within the same cycle, o_busy=0, o_last_src=0, o_ovf=0.
- Single request: i_btn_sec_plus at cycle 0 -> o_sec_plus high in cycle 2 only, o_last_src=0, o_busy low from cycle 8 (GAP_CYC=4).
- Simultaneous requests: i_btn_min_plus and i_uart_hour_plus both at cycle 0 -> o_min_plus in cycle 2, o_hour_plus in cycle 8, o_last_src 0 then 1.
- Lock and saturation: i_lock=1, nine i_uart_sec_plus pulses -> counter holds 7, o_ovf=1 after the 8th. Release lock -> exactly 7 o_sec_plus pulses spaced 6 cycles. Then i_ovf_clr -> o_ovf=0.
- Reset mid-operation: assert rst during ISSUE with 3 pending -> pulse cut immediately; after release, no pulses issued.
- Macro: with WATCH_ARB_UART_PRIO_EN, BTN sec and UART sec at cycle 0 with rr=BTN -> UART pulse in cycle 2 (o_last_src=1), BTN pulse in cycle 8.
